voice_allocator: RTL and testbench

Polyphonic voice scheduler that sits between the note-event source (MIDI/key scanner) and a bank of `NUM_VOICES` NCO instances. Accepts note-on/note-off events over a valid/ready handshake, chooses a voice (retrigger, free, or oldest-steal), and drives each NCO's `accumulator_increment_value` and `nco_mute`. All voice updates are committed only on a `sample_clk_en` cycle, so an NCO never changes frequency or mute state mid-sample.

---
 rtl/synth_pkg.sv | 21 ++
 rtl/voice_slot.sv | 46 ++++
 rtl/voice_allocator.sv | 161 ++++++++++++++++
 tb/tb_voice_allocator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and default widths for the voice allocator and its per-voice slots.
package synth_pkg;

    localparam int ACC_W  = 32;
    localparam int NOTE_W = 7;
    localparam int AGE_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } alloc_state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [ACC_W-1:0]  increment;
        logic              active;
        logic [AGE_W-1:0]  age;
    } voice_slot_t;

endpackage

// File: rtl/voice_slot.sv
// One voice: held note, NCO increment, active flag and saturating age counter
// with a single commit write port.
module voice_slot
    import synth_pkg::*;
#(
    parameter int ACC_W  = synth_pkg::ACC_W,
    parameter int NOTE_W = synth_pkg::NOTE_W,
    parameter int AGE_W  = synth_pkg::AGE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_clk_en,
    input  logic              commit_en,
    input  logic              commit_on,
    input  logic [NOTE_W-1:0] commit_note,
    input  logic [ACC_W-1:0]  commit_increment,
    output logic [NOTE_W-1:0] note,
    output logic [ACC_W-1:0]  increment,
    output logic              active,
    output logic [AGE_W-1:0]  age
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note      <= '0;
            increment <= '0;
            active    <= 1'b0;
            age       <= '0;
        end else if (commit_en) begin
            // A commit always restarts the age, overriding this sample's increment.
            age <= '0;
            if (commit_on) begin
                note      <= commit_note;
                increment <= commit_increment;
                active    <= 1'b1;
            end else begin
                active    <= 1'b0;
            end
        end else if (sample_clk_en && active && (age != '1)) begin
            age <= age + 1'b1;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans voices one per cycle for a retrigger match,
// a free slot or the oldest voice, then commits the event on a sample strobe.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = synth_pkg::ACC_W,
    parameter int NOTE_W     = synth_pkg::NOTE_W,
    parameter int AGE_W      = synth_pkg::AGE_W
) (
    input  logic                        master_clk,
    input  logic                        rst,
    input  logic                        sample_clk_en,
    input  logic                        evt_valid,
    output logic                        evt_ready,
    input  logic                        evt_on,
    input  logic [NOTE_W-1:0]           evt_note,
    input  logic [ACC_W-1:0]            evt_increment,
    output logic [NUM_VOICES*ACC_W-1:0] voice_increment,
    output logic [NUM_VOICES-1:0]       voice_mute,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic                        steal_pulse
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    alloc_state_t state, next_state;
    logic [IDX_W-1:0] scan_idx;
    logic commit_fire;

    logic              ev_on;
    logic [NOTE_W-1:0] ev_note;
    logic [ACC_W-1:0]  ev_increment;

    logic             match_found, free_found, oldest_found;
    logic [IDX_W-1:0] match_idx, free_idx, oldest_idx;
    logic [AGE_W-1:0] oldest_age;

    logic             target_valid, target_steal;
    logic [IDX_W-1:0] target_idx;

    logic [NOTE_W-1:0] v_note   [NUM_VOICES];
    logic [ACC_W-1:0]  v_inc    [NUM_VOICES];
    logic [AGE_W-1:0]  v_age    [NUM_VOICES];
    logic [NUM_VOICES-1:0] v_active;

    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        evt_ready   = 1'b0;
        commit_fire = 1'b0;
        case (state)
            IDLE: begin
                evt_ready = 1'b1;
                if (evt_valid) next_state = SCAN;
            end
            SCAN: begin
                if (scan_idx == IDX_W'(NUM_VOICES - 1)) next_state = COMMIT;
            end
            COMMIT: begin
                if (sample_clk_en) begin
                    commit_fire = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Note-on priority is retrigger > lowest free > oldest; note-off needs a match.
    always_comb begin
        target_valid = 1'b0;
        target_steal = 1'b0;
        target_idx   = match_idx;
        if (match_found) begin
            target_valid = 1'b1;
        end else if (ev_on && free_found) begin
            target_valid = 1'b1;
            target_idx   = free_idx;
        end else if (ev_on) begin
            target_valid = oldest_found;
            target_steal = oldest_found;
            target_idx   = oldest_idx;
        end
    end

    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            ev_on        <= 1'b0;
            ev_note      <= '0;
            ev_increment <= '0;
            scan_idx     <= '0;
            match_found  <= 1'b0;
            free_found   <= 1'b0;
            oldest_found <= 1'b0;
            match_idx    <= '0;
            free_idx     <= '0;
            oldest_idx   <= '0;
            oldest_age   <= '0;
            steal_pulse  <= 1'b0;
        end else begin
            steal_pulse <= commit_fire && target_valid && target_steal;
            if (state == IDLE && evt_valid) begin
                ev_on        <= evt_on;
                ev_note      <= evt_note;
                ev_increment <= evt_increment;
                scan_idx     <= '0;
                match_found  <= 1'b0;
                free_found   <= 1'b0;
                oldest_found <= 1'b0;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + 1'b1;
                if (!match_found && v_active[scan_idx] && v_note[scan_idx] == ev_note) begin
                    match_found <= 1'b1;
                    match_idx   <= scan_idx;
                end
                if (!free_found && !v_active[scan_idx]) begin
                    free_found <= 1'b1;
                    free_idx   <= scan_idx;
                end
                // Strictly-greater comparison keeps the lowest index on age ties.
                if (v_active[scan_idx] && (!oldest_found || v_age[scan_idx] > oldest_age)) begin
                    oldest_found <= 1'b1;
                    oldest_idx   <= scan_idx;
                    oldest_age   <= v_age[scan_idx];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        voice_slot #(
            .ACC_W (ACC_W),
            .NOTE_W(NOTE_W),
            .AGE_W (AGE_W)
        ) u_slot (
            .clk             (master_clk),
            .rst             (rst),
            .sample_clk_en   (sample_clk_en),
            .commit_en       (commit_fire && target_valid && (target_idx == IDX_W'(i))),
            .commit_on       (ev_on),
            .commit_note     (ev_note),
            .commit_increment(ev_increment),
            .note            (v_note[i]),
            .increment       (v_inc[i]),
            .active          (v_active[i]),
            .age             (v_age[i])
        );
        assign voice_increment[i*ACC_W +: ACC_W] = v_inc[i];
    end

    assign voice_active = v_active;
    assign voice_mute   = ~v_active;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: reset, allocation, retrigger, steal,
// note-off, dropped note-off and reset abort during COMMIT.
module tb_voice_allocator;

    localparam int NV = 4;

    logic          master_clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_clk_en = 1'b0;
    logic          evt_valid = 1'b0;
    logic          evt_ready;
    logic          evt_on = 1'b0;
    logic [6:0]    evt_note = '0;
    logic [31:0]   evt_increment = '0;
    logic [NV*32-1:0] voice_increment;
    logic [NV-1:0] voice_mute;
    logic [NV-1:0] voice_active;
    logic          steal_pulse;

    int tests = 0;
    int fails = 0;

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .master_clk     (master_clk),
        .rst            (rst),
        .sample_clk_en  (sample_clk_en),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_on         (evt_on),
        .evt_note       (evt_note),
        .evt_increment  (evt_increment),
        .voice_increment(voice_increment),
        .voice_mute     (voice_mute),
        .voice_active   (voice_active),
        .steal_pulse    (steal_pulse)
    );

    always #5 master_clk = ~master_clk;

    task automatic apply_reset();
        @(negedge master_clk);
        rst = 1'b1;
        repeat (3) @(negedge master_clk);
        rst = 1'b0;
        @(negedge master_clk);
    endtask

    task automatic pulse_sample();
        sample_clk_en = 1'b1;
        @(negedge master_clk);
        sample_clk_en = 1'b0;
    endtask

    // Presents one event, lets the scan finish and leaves the FSM parked in COMMIT.
    task automatic send_event(input logic on, input logic [6:0] note, input logic [31:0] inc);
        int n = 0;
        @(negedge master_clk);
        evt_valid = 1'b1;
        evt_on = on;
        evt_note = note;
        evt_increment = inc;
        while (!evt_ready && n < 1000) begin
            @(negedge master_clk);
            n++;
        end
        tests++;
        if (!evt_ready) begin
            fails++;
            $display("FAIL accept_timeout: evt_ready=%0b required 1 within 1000 cycles", evt_ready);
        end
        @(posedge master_clk);
        @(negedge master_clk);
        evt_valid = 1'b0;
        evt_note = 7'h7f;
        evt_increment = 32'hdead_beef;
        repeat (NV + 1) @(negedge master_clk);
        tests++;
        if (evt_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_in_commit: evt_ready=%0b required 0", evt_ready);
        end
    endtask

    task automatic do_event(input logic on, input logic [6:0] note, input logic [31:0] inc);
        send_event(on, note, inc);
        pulse_sample();
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (voice_mute !== 4'b1111) begin
            fails++; $display("FAIL reset_mute: got %b required 1111", voice_mute);
        end
        tests++;
        if (voice_increment !== '0) begin
            fails++; $display("FAIL reset_increment: got %h required 0", voice_increment);
        end
        tests++;
        if (evt_ready !== 1'b1 || voice_active !== 4'b0000 || steal_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: ready=%b active=%b steal=%b required 1 0000 0",
                     evt_ready, voice_active, steal_pulse);
        end
    endtask

    task automatic test_note_on();
        send_event(1'b1, 7'd60, 32'h0200_0000);
        tests++;
        if (voice_active !== 4'b0000) begin
            fails++; $display("FAIL hold_until_sample: active=%b required 0000", voice_active);
        end
        pulse_sample();
        tests++;
        if (voice_active !== 4'b0001 || voice_mute !== 4'b1110) begin
            fails++;
            $display("FAIL note_on_alloc: active=%b mute=%b required 0001 1110", voice_active, voice_mute);
        end
        tests++;
        if (voice_increment[31:0] !== 32'h0200_0000 || steal_pulse !== 1'b0) begin
            fails++;
            $display("FAIL note_on_inc: inc0=%h steal=%b required 02000000 0",
                     voice_increment[31:0], steal_pulse);
        end
        tests++;
        if (evt_ready !== 1'b1) begin
            fails++; $display("FAIL ready_after_commit: got %b required 1", evt_ready);
        end
    endtask

    task automatic test_retrigger();
        repeat (3) pulse_sample();
        tests++;
        if (dut.g_voice[0].u_slot.age !== 16'd3) begin
            fails++; $display("FAIL age_count: age0=%0d required 3", dut.g_voice[0].u_slot.age);
        end
        do_event(1'b1, 7'd60, 32'h0400_0000);
        tests++;
        if (voice_increment[31:0] !== 32'h0400_0000 || dut.g_voice[0].u_slot.age !== 16'd0) begin
            fails++;
            $display("FAIL retrigger: inc0=%h age0=%0d required 04000000 0",
                     voice_increment[31:0], dut.g_voice[0].u_slot.age);
        end
        tests++;
        if (voice_active !== 4'b0001 || voice_increment[127:32] !== '0) begin
            fails++;
            $display("FAIL retrigger_others: active=%b inc[3:1]=%h required 0001 0",
                     voice_active, voice_increment[127:32]);
        end
    endtask

    task automatic test_steal();
        apply_reset();
        do_event(1'b1, 7'd60, 32'h0000_0100);
        do_event(1'b1, 7'd62, 32'h0000_0200);
        do_event(1'b1, 7'd64, 32'h0000_0300);
        do_event(1'b1, 7'd65, 32'h0000_0400);
        tests++;
        if (voice_active !== 4'b1111 || voice_increment !== 128'h00000400_00000300_00000200_00000100) begin
            fails++;
            $display("FAIL fill_voices: active=%b inc=%h required 1111 00000400000003000000020000000100",
                     voice_active, voice_increment);
        end
        do_event(1'b1, 7'd67, 32'h0000_7777);
        tests++;
        if (steal_pulse !== 1'b1 || voice_increment[31:0] !== 32'h0000_7777) begin
            fails++;
            $display("FAIL steal_oldest: steal=%b inc0=%h required 1 00007777",
                     steal_pulse, voice_increment[31:0]);
        end
        tests++;
        if (voice_increment[63:32] !== 32'h0000_0200 || voice_active !== 4'b1111) begin
            fails++;
            $display("FAIL steal_others: inc1=%h active=%b required 00000200 1111",
                     voice_increment[63:32], voice_active);
        end
        @(negedge master_clk);
        tests++;
        if (steal_pulse !== 1'b0) begin
            fails++; $display("FAIL steal_one_cycle: steal=%b required 0", steal_pulse);
        end
    endtask

    task automatic test_note_off();
        logic [NV*32-1:0] inc_snap;
        logic [NV-1:0]    act_snap;
        do_event(1'b0, 7'd62, 32'h0);
        tests++;
        if (voice_active !== 4'b1101 || voice_mute !== 4'b0010 || voice_increment[63:32] !== 32'h0000_0200) begin
            fails++;
            $display("FAIL note_off: active=%b mute=%b inc1=%h required 1101 0010 00000200",
                     voice_active, voice_mute, voice_increment[63:32]);
        end
        inc_snap = voice_increment;
        act_snap = voice_active;
        do_event(1'b0, 7'd70, 32'h0);
        tests++;
        if (voice_active !== act_snap || voice_increment !== inc_snap || evt_ready !== 1'b1) begin
            fails++;
            $display("FAIL note_off_unheld: active=%b inc=%h ready=%b required %b %h 1",
                     voice_active, voice_increment, evt_ready, act_snap, inc_snap);
        end
        do_event(1'b1, 7'd72, 32'h0);
        tests++;
        if (voice_active !== 4'b1111 || voice_mute !== 4'b0000 || voice_increment[63:32] !== 32'h0 || steal_pulse !== 1'b0) begin
            fails++;
            $display("FAIL zero_inc_free: active=%b mute=%b inc1=%h steal=%b required 1111 0000 0 0",
                     voice_active, voice_mute, voice_increment[63:32], steal_pulse);
        end
    endtask

    task automatic test_reset_in_commit();
        apply_reset();
        send_event(1'b1, 7'd60, 32'h0200_0000);
        rst = 1'b1;
        repeat (2) @(negedge master_clk);
        rst = 1'b0;
        @(negedge master_clk);
        pulse_sample();
        pulse_sample();
        tests++;
        if (voice_active !== 4'b0000 || voice_mute !== 4'b1111 || voice_increment !== '0 || evt_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_abort: active=%b mute=%b inc=%h ready=%b required 0000 1111 0 1",
                     voice_active, voice_mute, voice_increment, evt_ready);
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_retrigger();
        test_steal();
        test_note_off();
        test_reset_in_commit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
